// File: rtl/pwm_capture_if.sv
// pwm_capture_if: bundles the PWM input pin and the measurement outputs of
// pwm_capture. The master modport is the capture block; the slave modport is
// whatever drives the pin and consumes the measurements.
interface pwm_capture_if #(
    parameter int WIDTH = 16
);
    logic             Input;
    logic [WIDTH-1:0] HighTime;
    logic [WIDTH-1:0] Period;
    logic             Valid;
    logic             Timeout;
    logic             Level;

    modport master (
        input  Input,
        output HighTime,
        output Period,
        output Valid,
        output Timeout,
        output Level
    );

    modport slave (
        output Input,
        input  HighTime,
        input  Period,
        input  Valid,
        input  Timeout,
        input  Level
    );
endinterface

// File: rtl/pwm_capture.sv
// pwm_capture: measures high time and period of an asynchronous PWM input in
// Clk cycles and reports one measurement per period with a one-cycle Valid.
// Optional glitch filter between synchroniser and Level: PWM_CAPTURE_FILTER_EN.
module pwm_capture #(
    parameter int WIDTH      = 16,
    parameter int FILTER_LEN = 4
) (
    input  logic          Clk,
    input  logic          Reset,
    pwm_capture_if.master bus
);
    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW
    } state_t;

    localparam logic [WIDTH-1:0] COUNT_MAX = '1;
    localparam logic [WIDTH-1:0] COUNT_ONE = WIDTH'(1);

    logic             sync_meta;
    logic             sync_s;
    logic             level;
    logic             level_d;
    logic             rise;
    logic             fall;

    state_t           state_q,   state_n;
    logic [WIDTH-1:0] count_q,   count_n;
    logic [WIDTH-1:0] latch_q,   latch_n;
    logic [WIDTH-1:0] high_q,    high_n;
    logic [WIDTH-1:0] period_q,  period_n;
    logic             valid_q,   valid_n;
    logic             timeout_q, timeout_n;
    logic [WIDTH-1:0] count_inc;

    // Two-flop synchroniser for the asynchronous pin.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sync_meta <= 1'b0;
            sync_s    <= 1'b0;
        end else begin
            // NOTE: non-blocking so both stages sample the pre-edge values and
            // the chain really is two flops deep.
            sync_meta <= bus.Input;
            sync_s    <= sync_meta;
        end
    end

`ifdef PWM_CAPTURE_FILTER_EN
    localparam logic [7:0] FILTER_MATCH = 8'(FILTER_LEN);
    logic [7:0] filt_cnt;

    // Level follows S only after S has differed from it for FILTER_LEN cycles.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            filt_cnt <= 8'd0;
            level    <= 1'b0;
        end else if (sync_s == level) begin
            filt_cnt <= 8'd0;
        end else if (filt_cnt + 8'd1 == FILTER_MATCH) begin
            level    <= sync_s;
            filt_cnt <= 8'd0;
        end else begin
            filt_cnt <= filt_cnt + 8'd1;
        end
    end
`else
    // Without the filter FILTER_LEN has no use; fold it into a dead tie-off.
    logic unused_filter_len;
    assign unused_filter_len = ^FILTER_LEN;
    assign level             = sync_s;
`endif

    // Previous level for edge detection.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) level_d <= 1'b0;
        else       level_d <= level;
    end

    assign rise      = level & ~level_d;
    assign fall      = ~level & level_d;
    assign count_inc = (count_q == COUNT_MAX) ? COUNT_MAX : count_q + COUNT_ONE;

    // Measurement state and registered outputs.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= IDLE;
            count_q   <= '0;
            latch_q   <= '0;
            high_q    <= '0;
            period_q  <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_n;
            count_q   <= count_n;
            latch_q   <= latch_n;
            high_q    <= high_n;
            period_q  <= period_n;
            valid_q   <= valid_n;
            timeout_q <= timeout_n;
        end
    end

    // Next-state and next-output decode of the IDLE/HIGH/LOW measurement FSM.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one
        // unassigned, which would infer a latch.
        state_n   = state_q;
        count_n   = count_q;
        latch_n   = latch_q;
        high_n    = high_q;
        period_n  = period_q;
        valid_n   = 1'b0;
        timeout_n = timeout_q;

        case (state_q)
            IDLE: begin
                count_n = '0;
                if (rise) begin
                    count_n = COUNT_ONE;
                    state_n = HIGH;
                end
            end
            HIGH: begin
                count_n = count_inc;
                if (fall) begin
                    latch_n = count_q;
                    state_n = LOW;
                end else if (count_q == COUNT_MAX) begin
                    timeout_n = 1'b1;
                    count_n   = '0;
                    state_n   = IDLE;
                end
            end
            LOW: begin
                count_n = count_inc;
                if (rise) begin
                    period_n  = count_q;
                    high_n    = latch_q;
                    valid_n   = 1'b1;
                    timeout_n = 1'b0;
                    count_n   = COUNT_ONE;
                    state_n   = HIGH;
                end else if (count_q == COUNT_MAX) begin
                    timeout_n = 1'b1;
                    count_n   = '0;
                    state_n   = IDLE;
                end
            end
            default: begin
                count_n = '0;
                state_n = IDLE;
            end
        endcase
    end

    assign bus.HighTime = high_q;
    assign bus.Period   = period_q;
    assign bus.Valid    = valid_q;
    assign bus.Timeout  = timeout_q;
    assign bus.Level    = level;
endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed PWM waveforms with hand-computed measurements.
// The driver pushes the expected (HighTime, Period) of every period whose
// closing rising edge it will produce; a monitor pops on each Valid.
module tb_pwm_capture;
    localparam int W  = 10;
    localparam int FL = 4;
`ifdef PWM_CAPTURE_FILTER_EN
    localparam int MIN_PULSE = FL;
`else
    localparam int MIN_PULSE = 1;
`endif

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] per;
    } meas_t;

    logic  Clk;
    logic  Reset;
    meas_t exp_q[$];
    meas_t exp_m;
    int    total;
    int    bad;
    int    last_hi;
    int    last_per;

    pwm_capture_if #(.WIDTH(W)) bus ();

    pwm_capture #(.WIDTH(W), .FILTER_LEN(FL)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string name, input int act, input int req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Hold the pin at v for n cycles; every step ends 1 time unit after a rising edge.
    task automatic drive(input logic v, input int n);
        bus.Input = v;
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic pwm_period(input int hi, input int per, input bit expect_it);
        if (expect_it) exp_q.push_back('{hi: W'(hi), per: W'(per)});
        drive(1'b1, hi);
        drive(1'b0, per - hi);
    endtask

    // Scoreboard monitor: every Valid must match the oldest expectation.
    always @(negedge Clk) begin
        if (!Reset && bus.Valid) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_valid: got HighTime=%0d Period=%0d, required no Valid",
                         bus.HighTime, bus.Period);
            end else begin
                exp_m = exp_q.pop_front();
                check("hightime", int'(bus.HighTime), int'(exp_m.hi));
                check("period", int'(bus.Period), int'(exp_m.per));
                check("timeout_at_valid", int'(bus.Timeout), 0);
                last_hi  = int'(exp_m.hi);
                last_per = int'(exp_m.per);
            end
        end
    end

    // Cycle budget: a hang is reported and stops the run.
    initial begin
        #300000;
        $display("FAIL watchdog: got no finish within 30000 cycles, required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        total     = 0;
        bad       = 0;
        last_hi   = 0;
        last_per  = 0;
        Reset     = 1'b1;
        bus.Input = 1'b0;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        check("reset_hightime", int'(bus.HighTime), 0);
        check("reset_period", int'(bus.Period), 0);
        check("reset_valid", int'(bus.Valid), 0);
        check("reset_timeout", int'(bus.Timeout), 0);
        check("reset_level", int'(bus.Level), 0);
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        drive(1'b0, 5);

        // 50% duty, then minimum and maximum duty.
        repeat (4) pwm_period(128, 256, 1'b1);
        repeat (3) pwm_period(MIN_PULSE, 256, 1'b1);
        repeat (3) pwm_period(256 - MIN_PULSE, 256, 1'b1);

        // Stop toggling: the last Rise delivers the previous measurement,
        // then the counter runs out in LOW.
        drive(1'b1, 128);
        drive(1'b0, 872);
        check("timeout_not_yet", int'(bus.Timeout), 0);
        drive(1'b0, 100);
        check("timeout_set", int'(bus.Timeout), 1);
        check("timeout_level", int'(bus.Level), 0);
        check("timeout_hold_hightime", int'(bus.HighTime), 256 - MIN_PULSE);
        check("timeout_hold_period", int'(bus.Period), 256);
        drive(1'b0, 50);
        check("timeout_sticky", int'(bus.Timeout), 1);

        // Restart: the first period after the timeout is measured once the
        // following Rise arrives; that Valid clears Timeout.
        repeat (3) pwm_period(64, 256, 1'b1);

        // Reset mid-HIGH with the pin toggling.
        drive(1'b1, 50);
        check("queue_drained_before_reset", exp_q.size(), 0);
        #3;
        Reset = 1'b1;
        #1;
        check("async_reset_hightime", int'(bus.HighTime), 0);
        check("async_reset_period", int'(bus.Period), 0);
        check("async_reset_timeout", int'(bus.Timeout), 0);
        check("async_reset_level", int'(bus.Level), 0);
        @(posedge Clk);
        #1;
        drive(1'b0, 1);
        drive(1'b1, 1);
        drive(1'b0, 1);
        Reset = 1'b0;
        drive(1'b0, 10);
        repeat (2) pwm_period(100, 300, 1'b1);

        // 100/400 waveform with a 2-cycle glitch in the LOW phase.
`ifdef PWM_CAPTURE_FILTER_EN
        exp_q.push_back('{hi: W'(100), per: W'(400)});
`else
        exp_q.push_back('{hi: W'(100), per: W'(200)});
        exp_q.push_back('{hi: W'(2), per: W'(200)});
`endif
        drive(1'b1, 100);
        drive(1'b0, 100);
        drive(1'b1, 2);
        drive(1'b0, 198);

        // Closing Rise for the glitch period's measurement.
        drive(1'b1, 30);
        check("queue_drained_at_end", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
- Receive-side counterpart of the team's 8-bit PWM generator: measures an incoming PWM waveform's high time and period in Clk cycles.
- Reports one measurement per PWM period, with a one-cycle valid strobe.
- Sits at an FPGA input pin: feedback check of on-board PWM outputs, or decoding of external PWM (servo/sensor) signals into register values.

Parameters:
- WIDTH, 16, width of the cycle counters and of the HighTime/Period outputs.
- FILTER_LEN, 4, glitch filter length in cycles; used only when PWM_CAPTURE_FILTER_EN is defined; legal range 1..255.

Ports:
- Clk  input  1  system clock; all logic on rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Input  input  1  PWM signal, asynchronous to Clk.
- HighTime  output  WIDTH  cycles Input was high in the last complete period.
- Period  output  WIDTH  cycles between the last two rising edges.
- Valid  output  1  one-cycle strobe; HighTime/Period updated in the same cycle.
- Timeout  output  1  sticky; signal stopped toggling (no edge within 2^WIDTH-1 cycles).
- Level  output  1  current synchronised (filtered) input level.

Behaviour:
- Interface: one clock Clk; Reset is asynchronous and active-high. All flops clear on Reset assertion, regardless of Clk.
- Reset values: HighTime=0, Period=0, Valid=0, Timeout=0, Level=0, state=IDLE, internal counters 0.
- Synchroniser: Input passes through 2 flops to give S. Without the filter, Level=S. Latency from pin to Level is 2 cycles (plus FILTER_LEN with the filter).
- Edge detect: Rise = Level & ~Level_d; Fall = ~Level & Level_d. Level_d resets to 0. Rise and Fall are mutually exclusive.
- Count is a WIDTH-bit counter. It saturates at 2^WIDTH-1 and never wraps.
- State IDLE:
  - Count held at 0.
  - On Rise: Count<=1, go to HIGH.
- State HIGH:
  - Count<=Count+1.
  - On Fall: HighLatch<=Count, go to LOW.
  - If Count==2^WIDTH-1 with no Fall: Timeout<=1, go to IDLE.
- State LOW:
  - Count<=Count+1.
  - On Rise: Period<=Count, HighTime<=HighLatch, Valid<=1 for exactly one cycle, Count<=1, go to HIGH.
  - If Count==2^WIDTH-1 with no Rise: Timeout<=1, go to IDLE.
- Resulting measurements: HighTime equals the number of cycles Level was high; Period equals the rising-edge-to-rising-edge distance. Valid is registered and asserts on the cycle after the Rise is detected.
- Timeout:
  - Sticky; cleared only by Reset or by the next Valid.
  - HighTime/Period hold their last values while Timeout=1.
  - Level shows the stuck level (constant 0 = 0% duty, constant 1 = 100% duty).
- First measurement after Reset or after a timeout: requires a Rise, a Fall and a second Rise. No Valid is generated for the partial period in progress.
- Reset mid-measurement: partial counts are discarded; behaviour is identical to power-up.
- Glitch within HIGH/LOW (filter disabled): treated as a real edge. The measurement is short, but the state machine stays consistent and never deadlocks.
- Outputs are stable between Valid strobes. No handshake; consumers sample on Valid.

Optional Feature:
- Macro: PWM_CAPTURE_FILTER_EN.
- Defined:
  - A filter stage sits between S and Level. An 8-bit counter increments while S!=Level and resets to 0 when S==Level.
  - When the counter reaches FILTER_LEN, Level<=S and the counter clears.
  - Pulses or gaps shorter than FILTER_LEN cycles are rejected.
  - Both edges are delayed equally by FILTER_LEN cycles, so HighTime and Period are unchanged for clean signals.
  - Filter counter resets to 0.
- Undefined: no filter logic is generated; Level=S; FILTER_LEN is unused.

Test Plan:
- Drive from the team's PWM generator with DutyCycle=128, same Clk. After the first two Valids: every Valid shows HighTime=128, Period=256, and Valid occurs every 256 cycles; Timeout=0.
- DutyCycle=1, then DutyCycle=255. Expect HighTime=1, Period=256, then HighTime=255, Period=256. At the change, exactly one period may show an intermediate value; no missed Valid.
- WIDTH=10, DutyCycle=0 (Input constant 0) after valid operation. Expect Timeout=1 exactly 1023 cycles after the last Rise, Level=0, HighTime/Period hold their previous values. Then restore DutyCycle=64: Timeout clears on the first new Valid, which shows HighTime=64, Period=256.
- Assert Reset for 3 cycles mid-HIGH while Input toggles. All outputs go to 0 immediately (asynchronous). The first Valid after release occurs at the second Rise detected after release.
- With PWM_CAPTURE_FILTER_EN, FILTER_LEN=4: inject a 2-cycle high glitch in the LOW phase of a 100/400 waveform. Expect no extra Valid and measurements HighTime=100, Period=400. Without the macro, the same stimulus yields a Valid with HighTime=2.
